// File: rtl/t03_fight_arbiter.sv
// Round controller and punch/block hit arbiter for two player FSMs; freezes them outside FIGHT.
// Latency: 1 cycle from frame_tick to health/state/hit outputs; no backpressure (tick-driven).
module t03_fight_arbiter #(
    parameter int              HP_W          = 4,
    parameter logic [HP_W-1:0] MAX_HEALTH    = 4'd8,
    parameter logic [HP_W-1:0] PUNCH_DMG     = 4'd2,
    parameter logic [HP_W-1:0] CHIP_DMG      = 4'd1,
    parameter logic [5:0]      INVULN_FRAMES = 6'd30,
    parameter logic [7:0]      KO_FRAMES     = 8'd120
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic            frame_tick,
    input  logic            start,
    input  logic [1:0]      p1_state,
    input  logic            p1_resting,
    input  logic [1:0]      p2_state,
    input  logic            p2_resting,
    output logic [HP_W-1:0] p1_health,
    output logic [HP_W-1:0] p2_health,
    output logic [1:0]      game_state,
    output logic [1:0]      winner,
    output logic            p1_hit,
    output logic            p2_hit,
    output logic            player_tick
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FIGHT = 2'b01,
        S_KO    = 2'b10
    } state_t;

    state_t          state;
    logic            atk1_q, atk2_q;
    logic [5:0]      inv1, inv2;
    logic [7:0]      ko_cnt;

    logic            atk1, atk2, blk1, blk2;
    logic            hit1, hit2;
    logic [HP_W-1:0] dmg1, dmg2;
    logic [HP_W-1:0] h1_nxt, h2_nxt;

    assign atk1 = (p1_state == 2'b01) && !p1_resting;
    assign atk2 = (p2_state == 2'b01) && !p2_resting;
    assign blk1 = (p1_state == 2'b10) && !p1_resting;
    assign blk2 = (p2_state == 2'b10) && !p2_resting;

    // Only a rising punch scores; a punch into invulnerability is simply lost.
    assign hit1 = atk2 && !atk2_q && (inv1 == 6'd0);
    assign hit2 = atk1 && !atk1_q && (inv2 == 6'd0);

    assign dmg1 = blk1 ? CHIP_DMG : PUNCH_DMG;
    assign dmg2 = blk2 ? CHIP_DMG : PUNCH_DMG;

    assign h1_nxt = !hit1 ? p1_health : ((p1_health > dmg1) ? p1_health - dmg1 : '0);
    assign h2_nxt = !hit2 ? p2_health : ((p2_health > dmg2) ? p2_health - dmg2 : '0);

    assign game_state  = state;
    assign player_tick = frame_tick && (state == S_FIGHT);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= S_IDLE;
            p1_health <= MAX_HEALTH;
            p2_health <= MAX_HEALTH;
            winner    <= 2'b00;
            p1_hit    <= 1'b0;
            p2_hit    <= 1'b0;
            atk1_q    <= 1'b0;
            atk2_q    <= 1'b0;
            inv1      <= 6'd0;
            inv2      <= 6'd0;
            ko_cnt    <= 8'd0;
        end else begin
            p1_hit <= 1'b0;
            p2_hit <= 1'b0;
            if (frame_tick) begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state     <= S_FIGHT;
                            p1_health <= MAX_HEALTH;
                            p2_health <= MAX_HEALTH;
                            winner    <= 2'b00;
                            atk1_q    <= 1'b0;
                            atk2_q    <= 1'b0;
                            inv1      <= 6'd0;
                            inv2      <= 6'd0;
                            ko_cnt    <= 8'd0;
                        end
                    end
                    S_FIGHT: begin
                        atk1_q    <= atk1;
                        atk2_q    <= atk2;
                        p1_health <= h1_nxt;
                        p2_health <= h2_nxt;
                        p1_hit    <= hit1;
                        p2_hit    <= hit2;
                        inv1 <= hit1 ? INVULN_FRAMES : ((inv1 != 6'd0) ? inv1 - 6'd1 : 6'd0);
                        inv2 <= hit2 ? INVULN_FRAMES : ((inv2 != 6'd0) ? inv2 - 6'd1 : 6'd0);
                        if ((h1_nxt == '0) || (h2_nxt == '0)) begin
                            state  <= S_KO;
                            winner <= {h1_nxt == '0, h2_nxt == '0};
                            ko_cnt <= 8'd0;
                        end
                    end
                    S_KO: begin
                        if (ko_cnt == KO_FRAMES - 8'd1) begin
                            state  <= S_IDLE;
                            ko_cnt <= 8'd0;
                        end else begin
                            ko_cnt <= ko_cnt + 8'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_t03_fight_arbiter.sv
// Directed bench for the fight arbiter: round sequencing, punch edges, blocking, invulnerability, KO, reset abort.
module tb_t03_fight_arbiter;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] p1_state = 2'b00;
    logic       p1_resting = 1'b0;
    logic [1:0] p2_state = 2'b00;
    logic       p2_resting = 1'b0;
    logic [3:0] p1_health, p2_health;
    logic [1:0] game_state, winner;
    logic       p1_hit, p2_hit, player_tick;

    int tests_run = 0;
    int tests_failed = 0;

    t03_fight_arbiter dut (
        .clk(clk), .nrst(nrst), .frame_tick(frame_tick), .start(start),
        .p1_state(p1_state), .p1_resting(p1_resting),
        .p2_state(p2_state), .p2_resting(p2_resting),
        .p1_health(p1_health), .p2_health(p2_health),
        .game_state(game_state), .winner(winner),
        .p1_hit(p1_hit), .p2_hit(p2_hit), .player_tick(player_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // All tasks start and end just after a falling edge.
    task automatic tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic new_round();
        p1_state = 2'b00; p2_state = 2'b00;
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Stimulus only: one strike tick, release, then wait until invulnerability expires.
    task automatic strike(input logic [1:0] s1, input logic [1:0] s2);
        p1_state = s1; p2_state = s2;
        tick();
        p1_state = 2'b00; p2_state = 2'b00;
        tick();
        idle_ticks(29);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        @(negedge clk);
        frame_tick = 1'b1;
        #1;
        tests_run++;
        if (game_state !== 2'b00 || winner !== 2'b00 || p1_health !== 4'd8 || p2_health !== 4'd8) begin
            $display("FAIL reset_state: gs=%b win=%b h1=%0d h2=%0d, want gs=00 win=00 h1=8 h2=8",
                     game_state, winner, p1_health, p2_health);
            tests_failed++;
        end
        tests_run++;
        if (p1_hit !== 1'b0 || p2_hit !== 1'b0 || player_tick !== 1'b0) begin
            $display("FAIL reset_pulses: p1_hit=%b p2_hit=%b ptick=%b, want 0 0 0", p1_hit, p2_hit, player_tick);
            tests_failed++;
        end
        @(negedge clk);
        frame_tick = 1'b0;
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start();
        tick();
        tests_run++;
        if (game_state !== 2'b00) begin
            $display("FAIL idle_no_start: gs=%b want 00", game_state);
            tests_failed++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (game_state !== 2'b01 || p1_health !== 4'd8 || p2_health !== 4'd8) begin
            $display("FAIL start_fight: gs=%b h1=%0d h2=%0d, want 01 8 8", game_state, p1_health, p2_health);
            tests_failed++;
        end
        frame_tick = 1'b1;
        #1;
        tests_run++;
        if (player_tick !== 1'b1) begin
            $display("FAIL ptick_high: ptick=%b want 1", player_tick);
            tests_failed++;
        end
        @(negedge clk);
        frame_tick = 1'b0;
        #1;
        tests_run++;
        if (player_tick !== 1'b0) begin
            $display("FAIL ptick_low: ptick=%b want 0", player_tick);
            tests_failed++;
        end
        @(negedge clk);
    endtask

    task automatic test_punch_held();
        int hits;
        new_round();
        p1_state = 2'b01;
        tick();
        tests_run++;
        if (p2_hit !== 1'b1 || p2_health !== 4'd6 || p1_hit !== 1'b0) begin
            $display("FAIL punch_hit: p2_hit=%b h2=%0d p1_hit=%b, want 1 6 0", p2_hit, p2_health, p1_hit);
            tests_failed++;
        end
        @(negedge clk);
        tests_run++;
        if (p2_hit !== 1'b0) begin
            $display("FAIL hit_one_cycle: p2_hit=%b want 0", p2_hit);
            tests_failed++;
        end
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (p2_hit === 1'b1) hits++;
        end
        tests_run++;
        if (hits != 0 || p2_health !== 4'd6) begin
            $display("FAIL held_punch: extra_hits=%0d h2=%0d, want 0 6", hits, p2_health);
            tests_failed++;
        end
        p1_state = 2'b00;
    endtask

    task automatic test_block_invuln();
        new_round();
        p1_state = 2'b01; p2_state = 2'b10;
        tick();
        tests_run++;
        if (p2_health !== 4'd7 || p2_hit !== 1'b1) begin
            $display("FAIL chip_damage: h2=%0d p2_hit=%b, want 7 1", p2_health, p2_hit);
            tests_failed++;
        end
        p1_state = 2'b00; p2_state = 2'b00;
        tick();
        p1_state = 2'b01;
        tick();
        tests_run++;
        if (p2_health !== 4'd7 || p2_hit !== 1'b0) begin
            $display("FAIL invuln_early: h2=%0d p2_hit=%b, want 7 0", p2_health, p2_hit);
            tests_failed++;
        end
        p1_state = 2'b00;
        tick();
        idle_ticks(26);
        p1_state = 2'b01;
        tick();
        tests_run++;
        if (p2_health !== 4'd7 || p2_hit !== 1'b0) begin
            $display("FAIL invuln_last_frame: h2=%0d p2_hit=%b, want 7 0", p2_health, p2_hit);
            tests_failed++;
        end
        p1_state = 2'b00;
        tick();
        p1_state = 2'b01;
        tick();
        tests_run++;
        if (p2_health !== 4'd5 || p2_hit !== 1'b1) begin
            $display("FAIL invuln_expired: h2=%0d p2_hit=%b, want 5 1", p2_health, p2_hit);
            tests_failed++;
        end
        p1_state = 2'b00;
    endtask

    task automatic test_double_ko();
        new_round();
        for (int i = 0; i < 3; i++) strike(2'b01, 2'b01);
        tests_run++;
        if (p1_health !== 4'd2 || p2_health !== 4'd2 || game_state !== 2'b01) begin
            $display("FAIL trade_to_2: h1=%0d h2=%0d gs=%b, want 2 2 01", p1_health, p2_health, game_state);
            tests_failed++;
        end
        p1_state = 2'b01; p2_state = 2'b01;
        tick();
        p1_state = 2'b00; p2_state = 2'b00;
        tests_run++;
        if (p1_health !== 4'd0 || p2_health !== 4'd0 || game_state !== 2'b10 || winner !== 2'b11
            || p1_hit !== 1'b1 || p2_hit !== 1'b1) begin
            $display("FAIL double_ko: h1=%0d h2=%0d gs=%b win=%b hits=%b%b, want 0 0 10 11 11",
                     p1_health, p2_health, game_state, winner, p1_hit, p2_hit);
            tests_failed++;
        end
    endtask

    task automatic test_ko_sequence();
        int bad_ptick;
        new_round();
        for (int i = 0; i < 3; i++) strike(2'b01, 2'b00);
        p1_state = 2'b01;
        tick();
        p1_state = 2'b00;
        tests_run++;
        if (game_state !== 2'b10 || winner !== 2'b01 || p2_health !== 4'd0 || p1_health !== 4'd8) begin
            $display("FAIL p1_wins: gs=%b win=%b h1=%0d h2=%0d, want 10 01 8 0",
                     game_state, winner, p1_health, p2_health);
            tests_failed++;
        end
        bad_ptick = 0;
        start = 1'b1;
        for (int i = 0; i < 119; i++) begin
            frame_tick = 1'b1;
            #1;
            if (player_tick !== 1'b0) bad_ptick++;
            @(negedge clk);
            frame_tick = 1'b0;
            if (game_state !== 2'b10) bad_ptick++;
        end
        start = 1'b0;
        tests_run++;
        if (bad_ptick != 0) begin
            $display("FAIL ko_hold: %0d bad samples of ptick/gs during KO, want 0", bad_ptick);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (game_state !== 2'b00 || winner !== 2'b01 || p2_health !== 4'd0) begin
            $display("FAIL ko_to_idle: gs=%b win=%b h2=%0d, want 00 01 0", game_state, winner, p2_health);
            tests_failed++;
        end
        tick();
        tests_run++;
        if (game_state !== 2'b00 || winner !== 2'b01 || p2_health !== 4'd0) begin
            $display("FAIL idle_hold: gs=%b win=%b h2=%0d, want 00 01 0", game_state, winner, p2_health);
            tests_failed++;
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests_run++;
        if (game_state !== 2'b01 || winner !== 2'b00 || p1_health !== 4'd8 || p2_health !== 4'd8) begin
            $display("FAIL restart: gs=%b win=%b h1=%0d h2=%0d, want 01 00 8 8",
                     game_state, winner, p1_health, p2_health);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_fight();
        new_round();
        strike(2'b10, 2'b01);
        strike(2'b00, 2'b01);
        p2_state = 2'b01;
        tick();
        p2_state = 2'b00;
        tests_run++;
        if (p1_health !== 4'd3 || p1_hit !== 1'b1 || game_state !== 2'b01) begin
            $display("FAIL setup_h3: h1=%0d p1_hit=%b gs=%b, want 3 1 01", p1_health, p1_hit, game_state);
            tests_failed++;
        end
        #1;
        nrst = 1'b0;
        #1;
        tests_run++;
        if (game_state !== 2'b00 || p1_health !== 4'd8 || p2_health !== 4'd8
            || p1_hit !== 1'b0 || p2_hit !== 1'b0 || winner !== 2'b00) begin
            $display("FAIL reset_abort: gs=%b h1=%0d h2=%0d hits=%b%b win=%b, want 00 8 8 00 00",
                     game_state, p1_health, p2_health, p1_hit, p2_hit, winner);
            tests_failed++;
        end
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_start();
        test_punch_held();
        test_block_invuln();
        test_double_ko();
        test_ko_sequence();
        test_reset_mid_fight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
